// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers for the synchronous FIFO core.
//   ptr_next(ptr, len) - increments a len-bit pointer held in the low bits
//                        of a 32-bit word, wrapping modulo 2^len.
// Widths depend on the FIFO parameters, so the helper works on a wide
// word and callers cast the result back to their pointer width.
package fifo_pkg;

  function automatic logic [31:0] ptr_next(input logic [31:0] ptr,
                                           input int unsigned len);
    logic [31:0] mask;
    mask = (32'd1 << len) - 32'd1;
    return (ptr + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: WIDTH x SIZE register-file storage for the FIFO core.
// Ports:
//   sys_clk - clock, all updates on rising edge
//   srst    - synchronous active-high reset (clears rdata only)
//   we      - write enable; wdata stored at waddr
//   waddr   - write address
//   wdata   - write data
//   re      - read enable; rdata loads mem[raddr]
//   raddr   - read address
//   rdata   - registered read data, holds when re is low
module fifo_mem #(
  parameter int SIZE    = 8,
  parameter int WIDTH   = 8,
  parameter int PTR_LEN = $clog2(SIZE)
) (
  input  logic               sys_clk,
  input  logic               srst,
  input  logic               we,
  input  logic [PTR_LEN-1:0] waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic               re,
  input  logic [PTR_LEN-1:0] raddr,
  output logic [WIDTH-1:0]   rdata
);

  logic [WIDTH-1:0] mem_q [SIZE];
  logic [WIDTH-1:0] mem_d [SIZE];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  // Storage is deliberately not reset; only the output register is.
  always_ff @(posedge sys_clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge sys_clk) begin
    if (srst) rdata_q <= '0;
    else      rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fifo_sync_core.sv
// fifo_sync_core: single-clock FIFO, buffering stage of the MAC
// encapsulation path.
// Ports:
//   sys_clk  - clock
//   srst     - synchronous active-high reset; clears pointers and data_out
//   w_en     - write request, accepted when not full
//   data_in  - write data
//   r_en     - read request, accepted when not empty
//   data_out - registered read data, valid the cycle after an accepted read
//   full     - combinational full flag (registered pointers only)
//   empty    - combinational empty flag (registered pointers only)
module fifo_sync_core
  import fifo_pkg::*;
#(
  parameter int SIZE    = 8,
  parameter int WIDTH   = 8,
  parameter int PTR_LEN = $clog2(SIZE)
) (
  input  logic             sys_clk,
  input  logic             srst,
  input  logic             w_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             r_en,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = PTR_LEN + 1;

  logic [PTR_LEN:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_LEN:0] rd_ptr_q, rd_ptr_d;
  logic             wr_acc;
  logic             rd_acc;

  // Extra MSB distinguishes a full buffer from an empty one when the
  // address bits coincide.
  assign empty = (rd_ptr_q == wr_ptr_q);
  assign full  = (rd_ptr_q[PTR_LEN] != wr_ptr_q[PTR_LEN]) &&
                 (rd_ptr_q[PTR_LEN-1:0] == wr_ptr_q[PTR_LEN-1:0]);

  assign wr_acc = w_en && !full;
  assign rd_acc = r_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) wr_ptr_d = PTR_W'(ptr_next(32'(wr_ptr_q), PTR_W));
    if (rd_acc) rd_ptr_d = PTR_W'(ptr_next(32'(rd_ptr_q), PTR_W));
  end

  always_ff @(posedge sys_clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Reset suppresses writes too so that a reset cycle never leaves a stale
  // word behind an address the pointers no longer cover.
  fifo_mem #(
    .SIZE    (SIZE),
    .WIDTH   (WIDTH),
    .PTR_LEN (PTR_LEN)
  ) u_mem (
    .sys_clk (sys_clk),
    .srst    (srst),
    .we      (wr_acc && !srst),
    .waddr   (wr_ptr_q[PTR_LEN-1:0]),
    .wdata   (data_in),
    .re      (rd_acc),
    .raddr   (rd_ptr_q[PTR_LEN-1:0]),
    .rdata   (data_out)
  );

endmodule

// File: tb/tb_fifo_sync_core.sv
module tb_fifo_sync_core;

  logic       sys_clk = 1'b0;
  logic       srst    = 1'b0;
  logic       w_en    = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       r_en    = 1'b0;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int n_vec = 0;
  int n_err = 0;

  fifo_sync_core #(.SIZE(8), .WIDTH(8)) dut (
    .sys_clk  (sys_clk),
    .srst     (srst),
    .w_en     (w_en),
    .data_in  (data_in),
    .r_en     (r_en),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock with the given requests; outputs sampled 1ns after the edge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    w_en    = w;
    data_in = d;
    r_en    = r;
    @(posedge sys_clk);
    #1;
    w_en = 1'b0;
    r_en = 1'b0;
  endtask

  function automatic logic [31:0] occ();
    logic [3:0] diff;
    diff = dut.wr_ptr_q - dut.rd_ptr_q;
    return {28'd0, diff};
  endfunction

  initial begin
    // Reset then idle
    srst = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    srst = 1'b0;
    chk("rst_empty", {31'd0, empty}, 1);
    chk("rst_full", {31'd0, full}, 0);
    chk("rst_dout", {24'd0, data_out}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("rd_empty_ptr", {28'd0, dut.rd_ptr_q}, 0);
      chk("rd_empty_dout", {24'd0, data_out}, 8'h00);
      chk("rd_empty_flag", {31'd0, empty}, 1);
    end

    // Three writes, three reads
    cyc(1'b1, 8'h11, 1'b0);
    chk("w1_empty", {31'd0, empty}, 0);
    cyc(1'b1, 8'h22, 1'b0);
    cyc(1'b1, 8'h33, 1'b0);
    chk("w3_occ", occ(), 3);
    cyc(1'b0, 8'h00, 1'b1);
    chk("r1_dout", {24'd0, data_out}, 8'h11);
    cyc(1'b0, 8'h00, 1'b1);
    chk("r2_dout", {24'd0, data_out}, 8'h22);
    cyc(1'b0, 8'h00, 1'b1);
    chk("r3_dout", {24'd0, data_out}, 8'h33);
    chk("r3_empty", {31'd0, empty}, 1);

    // Fill to capacity
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      chk("fill_full", {31'd0, full}, (i == 7) ? 1 : 0);
    end
    cyc(1'b1, 8'hFF, 1'b0);
    chk("ovf_full", {31'd0, full}, 1);
    chk("ovf_occ", occ(), 8);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("drain_dout", {24'd0, data_out}, 32'(i));
      chk("drain_full", {31'd0, full}, 0);
    end
    chk("drain_empty", {31'd0, empty}, 1);

    // Wrap-around with single write/read pairs
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 8'h40 + 8'(i), 1'b0);
      chk("wrap_w_empty", {31'd0, empty}, 0);
      chk("wrap_w_full", {31'd0, full}, 0);
      cyc(1'b0, 8'h00, 1'b1);
      chk("wrap_dout", {24'd0, data_out}, 32'h40 + 32'(i));
      chk("wrap_r_empty", {31'd0, empty}, 1);
    end

    // Simultaneous when empty: write only
    cyc(1'b1, 8'h5A, 1'b1);
    chk("sim_e_occ", occ(), 1);
    chk("sim_e_dout", {24'd0, data_out}, 8'h53);
    cyc(1'b0, 8'h00, 1'b1);
    chk("sim_e_rd", {24'd0, data_out}, 8'h5A);

    // Simultaneous when full: read only
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'h80 + 8'(i), 1'b0);
    chk("sim_f_pre", {31'd0, full}, 1);
    cyc(1'b1, 8'hEE, 1'b1);
    chk("sim_f_occ", occ(), 7);
    chk("sim_f_dout", {24'd0, data_out}, 8'h80);
    chk("sim_f_full", {31'd0, full}, 0);
    for (int i = 1; i < 8; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("sim_f_drain", {24'd0, data_out}, 32'h80 + 32'(i));
    end
    chk("sim_f_empty", {31'd0, empty}, 1);

    // Simultaneous with occupancy 3
    cyc(1'b1, 8'hA1, 1'b0);
    cyc(1'b1, 8'hA2, 1'b0);
    cyc(1'b1, 8'hA3, 1'b0);
    cyc(1'b1, 8'hA4, 1'b1);
    chk("sim_3_occ", occ(), 3);
    chk("sim_3_dout", {24'd0, data_out}, 8'hA1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("sim_3_r1", {24'd0, data_out}, 8'hA2);
    cyc(1'b0, 8'h00, 1'b1);
    chk("sim_3_r2", {24'd0, data_out}, 8'hA3);
    cyc(1'b0, 8'h00, 1'b1);
    chk("sim_3_r3", {24'd0, data_out}, 8'hA4);
    chk("sim_3_empty", {31'd0, empty}, 1);

    // Reset with 5 entries stored, overriding same-cycle requests
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'hB0 + 8'(i), 1'b0);
    chk("pre_rst_occ", occ(), 5);
    srst = 1'b1;
    cyc(1'b1, 8'hDD, 1'b1);
    srst = 1'b0;
    chk("mid_rst_empty", {31'd0, empty}, 1);
    chk("mid_rst_full", {31'd0, full}, 0);
    chk("mid_rst_dout", {24'd0, data_out}, 8'h00);
    chk("mid_rst_occ", occ(), 0);
    cyc(1'b1, 8'hC1, 1'b0);
    cyc(1'b1, 8'hC2, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("post_rst_r1", {24'd0, data_out}, 8'hC1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("post_rst_r2", {24'd0, data_out}, 8'hC2);
    chk("post_rst_empty", {31'd0, empty}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
